// File: rtl/control_fsm.sv
// control_fsm: multi-cycle instruction control FSM; ILLEGAL_TRAP_EN traps illegal instructions into HALT
module control_fsm #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op_control,
  input  logic [OP_W-1:0] funct_control,
  input  logic            zero,
  output logic            store,
  output logic            w_reg,
  output logic            w_data,
  output logic [OP_W-1:0] op_alu,
  output logic [31:0]     instr_count,
  output logic            halt
);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] FN_ADD  = OP_W'(6'b100000);
  localparam logic [OP_W-1:0] ALU_NOP  = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(6'b000001);
  localparam logic [OP_W-1:0] ALU_ADDI = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(6'b000011);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  state_t          state;
  logic [OP_W-1:0] op, funct;

  // zero only steers the datapath branch mux, never the control flow
  logic unused_zero;
  assign unused_zero = zero;

  logic            dec_add, dec_imm, dec_flow, dec_legal;
  logic [OP_W-1:0] dec_alu;
  assign dec_add   = op_control == OP_R && funct_control == FN_ADD;
  assign dec_imm   = op_control == OP_ADDI || op_control == OP_LW || op_control == OP_SW;
  assign dec_flow  = op_control == OP_BEQ || op_control == OP_J;
  assign dec_legal = dec_add || dec_imm || dec_flow;
  assign dec_alu   = dec_add ? ALU_ADD : dec_imm ? ALU_ADDI : op_control == OP_BEQ ? ALU_SUB : ALU_NOP;

  logic ex_wb, ex_mem;
  assign ex_wb  = (op == OP_R && funct == FN_ADD) || op == OP_ADDI;
  assign ex_mem = op == OP_LW || op == OP_SW;

  // state register with outputs registered for the state being entered
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= FETCH;
      op          <= '0;
      funct       <= '0;
      instr_count <= '0;
      store       <= 1'b0;
      w_reg       <= 1'b0;
      w_data      <= 1'b0;
      op_alu      <= '0;
    end else begin
      store  <= 1'b0;
      w_reg  <= 1'b0;
      w_data <= 1'b0;
      if (store) instr_count <= instr_count + 32'd1;
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          op    <= op_control;
          funct <= funct_control;
`ifdef ILLEGAL_TRAP_EN
          if (!dec_legal) state <= HALT;
          else begin
            state  <= EXEC;
            op_alu <= dec_alu;
            store  <= dec_flow;
          end
`else
          state  <= EXEC;
          op_alu <= dec_alu;
          store  <= dec_flow || !dec_legal;
`endif
        end
        EXEC: begin
          state  <= ex_wb ? WB : ex_mem ? MEM : FETCH;
          w_reg  <= ex_wb;
          w_data <= op == OP_SW;
          store  <= ex_wb || op == OP_SW;
          if (!ex_wb && !ex_mem) op_alu <= ALU_NOP;
        end
        MEM: begin
          state  <= op == OP_LW ? WB : FETCH;
          w_reg  <= op == OP_LW;
          store  <= op == OP_LW;
          if (op != OP_LW) op_alu <= ALU_NOP;
        end
        WB: begin
          state  <= FETCH;
          op_alu <= ALU_NOP;
        end
        HALT: state <= HALT;
        default: state <= FETCH;
      endcase
    end

`ifdef ILLEGAL_TRAP_EN
  // halt flag set on entry to HALT, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst) halt <= 1'b0;
    else if (state == DECODE && !dec_legal) halt <= 1'b1;
`else
  assign halt = 1'b0;
`endif
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: table-driven, hand-written and randomized checks of control_fsm
module tb_control_fsm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  op_control = '0;
  logic [5:0]  funct_control = '0;
  logic        zero = 1'b0;
  logic        store, w_reg, w_data, halt;
  logic [5:0]  op_alu;
  logic [31:0] instr_count;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_count = '0;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  control_fsm #(.OP_W(6)) dut (
    .clk(clk), .rst(rst), .op_control(op_control), .funct_control(funct_control),
    .zero(zero), .store(store), .w_reg(w_reg), .w_data(w_data), .op_alu(op_alu),
    .instr_count(instr_count), .halt(halt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         lat;
    logic [5:0] alu;
    logic       wr;
    logic       wd;
    logic       trap;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic [5:0] ealu,
                     input logic es, input logic ew, input logic ed, input logic eh,
                     input logic [31:0] ec);
    tests++;
    if ({store, w_reg, w_data, halt, op_alu, instr_count} !== {es, ew, ed, eh, ealu, ec}) begin
      fails++;
      $display("FAIL %s cycle %0d: got store=%b w_reg=%b w_data=%b halt=%b op_alu=%b count=%0d, want store=%b w_reg=%b w_data=%b halt=%b op_alu=%b count=%0d",
               name, k, store, w_reg, w_data, halt, op_alu, instr_count, es, ew, ed, eh, ealu, ec);
    end
  endtask

  // asserts reset mid-cycle, checks the immediate clear, leaves the bench in cycle 1 (FETCH)
  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_count = '0;
    chk("reset_async", 0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // reference behaviour of one instruction, straight from the opcode table
  function automatic void model(input logic [5:0] o, input logic [5:0] f, output int lat,
                                output logic [5:0] alu, output logic wr, output logic wd,
                                output logic trap);
    lat = 3; alu = 6'd0; wr = 1'b0; wd = 1'b0; trap = 1'b0;
    if (o == 6'b000000 && f == 6'b100000) begin lat = 4; alu = 6'd1; wr = 1'b1; end
    else if (o == 6'b001000) begin lat = 4; alu = 6'd2; wr = 1'b1; end
    else if (o == 6'b100011) begin lat = 5; alu = 6'd2; wr = 1'b1; end
    else if (o == 6'b101011) begin lat = 4; alu = 6'd2; wd = 1'b1; end
    else if (o == 6'b000100) alu = 6'd3;
    else if (o == 6'b000010) alu = 6'd0;
    else trap = TRAP;
  endfunction

  // runs one instruction from cycle 1 (FETCH) and checks every cycle of it
  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int lat, input logic [5:0] alu,
                           input logic wr, input logic wd, input logic trap);
    op_control = o;
    funct_control = f;
    zero = z;
    if (trap) begin
      for (int k = 1; k <= 6; k++) begin
        if (k > 1) step();
        chk(name, k, 6'd0, 1'b0, 1'b0, 1'b0, k >= 3, exp_count);
      end
      do_reset();
    end else begin
      for (int k = 1; k <= lat; k++) begin
        if (k > 1) step();
        chk(name, k, k >= 3 ? alu : 6'd0, k == lat, k == lat && wr, k == lat && wd, 1'b0, exp_count);
      end
      exp_count++;
      step();
    end
  endtask

  initial begin
    vecs[0] = '{6'b000000, 6'b100000, 1'b0, 4, 6'd1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{6'b100011, 6'b000000, 1'b0, 5, 6'd2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{6'b101011, 6'b000000, 1'b0, 4, 6'd2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{6'b000100, 6'b000000, 1'b1, 3, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{6'b000100, 6'b000000, 1'b0, 3, 6'd3, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{6'b000010, 6'b000000, 1'b1, 3, 6'd0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{6'b001000, 6'b000000, 1'b0, 4, 6'd2, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{6'b000000, 6'b100010, 1'b0, 3, 6'd0, 1'b0, 1'b0, TRAP};
    vecs[8] = '{6'b111111, 6'b000000, 1'b0, 3, 6'd0, 1'b0, 1'b0, TRAP};

    #2;
    do_reset();
    for (int i = 0; i < 9; i++)
      run_instr($sformatf("vec%0d", i), vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].lat,
                vecs[i].alu, vecs[i].wr, vecs[i].wd, vecs[i].trap);
    chk("after_table", 1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count);

    // build up a nonzero count, then reset just as SW enters MEM
    run_instr("pre_add", 6'b000000, 6'b100000, 1'b0, 4, 6'd1, 1'b1, 1'b0, 1'b0);
    run_instr("pre_addi", 6'b001000, 6'b000000, 1'b0, 4, 6'd2, 1'b1, 1'b0, 1'b0);
    op_control = 6'b101011;
    funct_control = 6'b000000;
    step();
    step();
    chk("sw_exec", 3, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, exp_count);
    #7;
    rst = 1'b1;
    #1;
    chk("sw_rst_now", 4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("sw_rst_mem", 4, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    chk("sw_rst_after", 5, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    exp_count = '0;
    @(negedge clk);
    rst = 1'b0;
    run_instr("post_rst_beq", 6'b000100, 6'b000000, 1'b1, 3, 6'd3, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] o, f, alu;
      logic       wr, wd, tr;
      int         sel, lat;
      sel = $urandom_range(0, 7);
      case (sel)
        0: o = 6'b000000;
        1: o = 6'b000010;
        2: o = 6'b001000;
        3: o = 6'b000100;
        4: o = 6'b100011;
        5: o = 6'b101011;
        default: o = 6'($urandom);
      endcase
      f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b100000;
      model(o, f, lat, alu, wr, wd, tr);
      run_instr($sformatf("rnd%0d", i), o, f, 1'($urandom), lat, alu, wr, wd, tr);
    end
    chk("final", 1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp_count);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
